// File: rtl/demux16_1to4_buf.sv
// 1-to-4 stream demultiplexer: one source fanned out to four buffered valid/ready sinks,
// each with a one-entry holding register and a wrapping accepted-word counter.
module demux16_1to4_buf #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [1:0]           in_sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [4*WIDTH-1:0]   out_data,
   output logic [3:0]           out_valid,
   input  logic [3:0]           out_ready,
   input  logic                 cnt_clr,
   output logic [4*CNT_W-1:0]   cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ch_state_e;

   ch_state_e        state_q [4];
   ch_state_e        state_d [4];
   logic [WIDTH-1:0] data_q  [4];
   logic [WIDTH-1:0] data_d  [4];
   logic [CNT_W-1:0] cnt_q   [4];
   logic [CNT_W-1:0] cnt_d   [4];
   logic             accept;
   logic [3:0]       load;
   logic [3:0]       drain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < 4; k++) begin
            state_q[k] <= EMPTY;
            data_q[k]  <= '0;
            cnt_q[k]   <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            state_q[k] <= state_d[k];
            data_q[k]  <= data_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
      end
   end

   // A full channel still accepts when its sink drains in the same cycle (no bubble).
   always_comb begin
      in_ready = rst_n & ((state_q[in_sel] == EMPTY) | out_ready[in_sel]);
      accept   = in_valid & in_ready;
      load     = '0;
      drain    = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         load[k]    = accept & (in_sel == 2'(k));
         drain[k]   = (state_q[k] == FULL) & out_ready[k];
         state_d[k] = state_q[k];
         data_d[k]  = data_q[k];
         cnt_d[k]   = cnt_q[k];
         if (load[k]) begin
            state_d[k] = FULL;
            data_d[k]  = in_data;
         end else if (drain[k]) begin
            state_d[k] = EMPTY;
         end
         if (cnt_clr) begin
            cnt_d[k] = '0;
         end else if (load[k]) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      out_data  = '0;
      out_valid = '0;
      cnt       = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         out_data[k*WIDTH +: WIDTH] = data_q[k];
         out_valid[k]               = (state_q[k] == FULL);
         cnt[k*CNT_W +: CNT_W]      = cnt_q[k];
      end
   end

endmodule
